vita49_unpack_mc: RTL and testbench

//  Multi-stream VITA-49 IF-data unpacker. Sits between the packet receive path and the sample consumers.

---
 rtl/vita49_pkg.sv | 39 +++
 rtl/vita49_unpack_mc_if.sv | 16 +
 rtl/vita49_in_reg.sv | 38 +++
 rtl/vita49_unpack_mc.sv | 279 +++++++++++++++++++++++++++
 tb/tb_vita49_unpack_mc.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vita49_pkg.sv
// rtl/vita49_pkg.sv - shared types, header field positions and helpers for the VITA-49 unpacker
// Purpose : FSM state encoding, IF-data header bit positions, header-length helpers.
// Ports   : none (package).
package vita49_pkg;

  typedef enum logic [3:0] {
    ST_INIT, ST_HDR, ST_SID, ST_CID0, ST_CID1,
    ST_TSI, ST_TSF0, ST_TSF1, ST_PAYLOAD, ST_DROP
  } state_t;

  localparam int HDR_TYPE_HI = 31;
  localparam int HDR_TYPE_LO = 28;
  localparam int HDR_C       = 27;
  localparam int HDR_T       = 26;
  localparam int HDR_TSI_HI  = 23;
  localparam int HDR_TSI_LO  = 22;
  localparam int HDR_TSF_HI  = 21;
  localparam int HDR_TSF_LO  = 20;
  localparam int HDR_CNT_HI  = 19;
  localparam int HDR_CNT_LO  = 16;
  localparam int HDR_SIZE_HI = 15;
  localparam int HDR_SIZE_LO = 0;

  localparam logic [3:0] PKT_TYPE_IFDATA = 4'b0001;

  // Words in front of the payload: header + stream ID, optional 2-word class ID,
  // 1-word integer timestamp, 2-word fractional timestamp.
  function automatic logic [15:0] hdr_len(input logic c, input logic tsi_nz, input logic tsf_nz);
    return 16'd2 + (c ? 16'd2 : 16'd0) + (tsi_nz ? 16'd1 : 16'd0) + (tsf_nz ? 16'd2 : 16'd0);
  endfunction

  // Next state once the class ID (or its absence) has been dealt with.
  function automatic state_t after_cid(input logic tsi_nz, input logic tsf_nz);
    if (tsi_nz)      return ST_TSI;
    else if (tsf_nz) return ST_TSF0;
    else             return ST_PAYLOAD;
  endfunction

endpackage

// File: rtl/vita49_unpack_mc_if.sv
// rtl/vita49_unpack_mc_if.sv - AXI-Stream bundle used on both sides of the unpacker
// Purpose : groups TDATA/TDEST/TVALID/TLAST/TREADY of one stream.
// Ports   : master drives TDATA, TDEST, TVALID, TLAST and samples TREADY;
//           slave samples TDATA, TVALID, TLAST and drives TREADY (no TDEST on input).
interface vita49_unpack_mc_if #(
  parameter int DEST_W = 2
);
  logic [31:0]       TDATA;
  logic [DEST_W-1:0] TDEST;
  logic              TVALID;
  logic              TLAST;
  logic              TREADY;

  modport master (output TDATA, output TDEST, output TVALID, output TLAST, input TREADY);
  modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/vita49_in_reg.sv
// rtl/vita49_in_reg.sv - one-entry AXI-Stream input register
// Purpose : holds one word (data, last) until the consumer takes it.
// Ports   : clk/rst (async high), clr sync flush, s_* upstream handshake,
//           consume from the consumer, q_* registered word.
module vita49_in_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        consume,
  output logic        q_valid,
  output logic [31:0] q_data,
  output logic        q_last
);

  // Refill in the same cycle the held word leaves, so a steady stream runs at one word per clock.
  assign s_ready = !q_valid || consume;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_last  <= 1'b0;
    end else if (clr) begin
      q_valid <= 1'b0;
    end else if (s_valid && s_ready) begin
      q_valid <= 1'b1;
      q_data  <= s_data;
      q_last  <= s_last;
    end else if (consume) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/vita49_unpack_mc.sv
// rtl/vita49_unpack_mc.sv - multi-stream VITA-49 IF-data unpacker
// Purpose : matches stream IDs against N_CH channels, strips header/CID/TSI/TSF/trailer,
//           forwards payload tagged with TDEST = channel, tracks order and size errors.
// Ports   : AXIS_ACLK, AXIS_ARESET (async high); s_axis word input; m_axis payload output;
//           trig/ctrl[0] start, ctrl[1] soft reset, ctrl[2] passthrough; stream_id/ch_en
//           channel table; status summary; seven saturating statistics counters.
module vita49_unpack_mc
  import vita49_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CH_W  = 2,
  parameter int CNT_W = 32
) (
  input  logic                   AXIS_ACLK,
  input  logic                   AXIS_ARESET,
  vita49_unpack_mc_if.slave      s_axis,
  vita49_unpack_mc_if.master     m_axis,
  input  logic                   trig,
  input  logic [31:0]            ctrl,
  input  logic [32*N_CH-1:0]     stream_id,
  input  logic [N_CH-1:0]        ch_en,
  output logic [31:0]            status,
  output logic [CNT_W-1:0]       pkt_recv,
  output logic [CNT_W-1:0]       pkt_dropped,
  output logic [CNT_W-1:0]       pkt_size_err,
  output logic [CNT_W-1:0]       pkt_type_err,
  output logic [CNT_W-1:0]       pkt_order_err,
  output logic [CNT_W-1:0]       ts_order_err,
  output logic [CNT_W-1:0]       strm_id_err
);

  localparam int C_RECV = 0, C_DROP = 1, C_SIZE = 2, C_TYPE = 3, C_ORDER = 4, C_TS = 5, C_SID = 6;

  logic soft_rst, pass;
  assign soft_rst = ctrl[1];
  assign pass     = ctrl[2];
  logic unused_ctrl;
  assign unused_ctrl = &{1'b0, ctrl[31:3]};

  state_t            state_q, state_d;
  logic              in_valid, in_last, consume;
  logic [31:0]       in_data;
  logic [15:0]       words_left_q, words_left_d;
  logic              c_q, t_q, tsi_q, tsf_q;
  logic [3:0]        cnt_q;
  logic [CH_W-1:0]   ch_q;
  logic [3:0]        exp_cnt [N_CH];
  logic [31:0]       last_tsi [N_CH];
  logic [CNT_W-1:0]  cnt_r [7];
  logic [6:0]        cnt_inc;

  logic              m_valid_q, m_last_q;
  logic [31:0]       m_data_q;
  logic [CH_W-1:0]   m_dest_q;
  logic              out_free, out_push, out_last_d;
  logic [CH_W-1:0]   out_dest_d;
  logic              load_hdr, ch_load, upd_exp, upd_tsi;

  vita49_in_reg u_in_reg (
    .clk     (AXIS_ACLK),
    .rst     (AXIS_ARESET),
    .clr     (soft_rst),
    .s_data  (s_axis.TDATA),
    .s_valid (s_axis.TVALID),
    .s_last  (s_axis.TLAST),
    .s_ready (s_axis.TREADY),
    .consume (consume),
    .q_valid (in_valid),
    .q_data  (in_data),
    .q_last  (in_last)
  );

  // Stream-ID priority encoder: scanning downwards leaves the lowest matching index.
  logic            match;
  logic [CH_W-1:0] match_idx;
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (ch_en[k] && stream_id[32*k +: 32] == in_data) begin
        match     = 1'b1;
        match_idx = CH_W'(k);
      end
    end
  end

  logic [15:0] hdr_size;
  logic        hdr_c, hdr_t, hdr_tsi_nz, hdr_tsf_nz, wl_end, early_last;
  assign hdr_size   = in_data[HDR_SIZE_HI:HDR_SIZE_LO];
  assign hdr_c      = in_data[HDR_C];
  assign hdr_t      = in_data[HDR_T];
  assign hdr_tsi_nz = |in_data[HDR_TSI_HI:HDR_TSI_LO];
  assign hdr_tsf_nz = |in_data[HDR_TSF_HI:HDR_TSF_LO];
  assign wl_end     = (words_left_q == 16'd1);
  assign early_last = in_last && !wl_end;
  assign out_free   = !m_valid_q || m_axis.TREADY;

  logic   body, sid_drop;
  state_t nom_next;

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    consume      = 1'b0;
    out_push     = 1'b0;
    out_last_d   = 1'b0;
    out_dest_d   = ch_q;
    cnt_inc      = '0;
    load_hdr     = 1'b0;
    ch_load      = 1'b0;
    upd_exp      = 1'b0;
    upd_tsi      = 1'b0;
    body         = 1'b0;
    sid_drop     = 1'b0;
    nom_next     = state_q;
    if (pass) begin
      if (in_valid && out_free) begin
        consume    = 1'b1;
        out_push   = 1'b1;
        out_last_d = in_last;
        out_dest_d = '0;
      end
    end else begin
      unique case (state_q)
        ST_INIT: if (ctrl[0] && trig) state_d = ST_HDR;
        ST_HDR: if (in_valid) begin
          consume         = 1'b1;
          load_hdr        = 1'b1;
          cnt_inc[C_RECV] = 1'b1;
          words_left_d    = hdr_size - 16'd1;
          if (in_data[HDR_TYPE_HI:HDR_TYPE_LO] != PKT_TYPE_IFDATA) begin
            cnt_inc[C_TYPE] = 1'b1;
            cnt_inc[C_DROP] = 1'b1;
            state_d         = in_last ? ST_HDR : ST_DROP;
          end else if (hdr_size < hdr_len(hdr_c, hdr_tsi_nz, hdr_tsf_nz) + {15'd0, hdr_t}) begin
            cnt_inc[C_SIZE] = 1'b1;
            cnt_inc[C_DROP] = 1'b1;
            state_d         = in_last ? ST_HDR : ST_DROP;
          end else if (in_last) begin
            cnt_inc[C_SIZE] = 1'b1;
          end else begin
            state_d = ST_SID;
          end
        end
        ST_SID: if (in_valid) begin
          consume = 1'b1;
          body    = 1'b1;
          if (!match) begin
            cnt_inc[C_SID]  = 1'b1;
            cnt_inc[C_DROP] = 1'b1;
            sid_drop        = 1'b1;
          end else begin
            ch_load = 1'b1;
            upd_exp = 1'b1;
            if (cnt_q != exp_cnt[match_idx] + 4'd1) cnt_inc[C_ORDER] = 1'b1;
            nom_next = c_q ? ST_CID0 : after_cid(tsi_q, tsf_q);
          end
        end
        ST_CID0: if (in_valid) begin consume = 1'b1; body = 1'b1; nom_next = ST_CID1; end
        ST_CID1: if (in_valid) begin consume = 1'b1; body = 1'b1; nom_next = after_cid(tsi_q, tsf_q); end
        ST_TSI: if (in_valid) begin
          consume = 1'b1;
          body    = 1'b1;
          upd_tsi = 1'b1;
          if (in_data < last_tsi[ch_q]) cnt_inc[C_TS] = 1'b1;
          nom_next = tsf_q ? ST_TSF0 : ST_PAYLOAD;
        end
        ST_TSF0: if (in_valid) begin consume = 1'b1; body = 1'b1; nom_next = ST_TSF1; end
        ST_TSF1: if (in_valid) begin consume = 1'b1; body = 1'b1; nom_next = ST_PAYLOAD; end
        ST_PAYLOAD: begin
          nom_next = ST_PAYLOAD;
          if (in_valid && t_q && wl_end) begin
            // Trailer: swallowed, needs no output slot.
            consume = 1'b1;
            body    = 1'b1;
          end else if (in_valid && out_free) begin
            consume    = 1'b1;
            body       = 1'b1;
            out_push   = 1'b1;
            out_last_d = in_last || (words_left_q == (t_q ? 16'd2 : 16'd1));
          end
        end
        ST_DROP: if (in_valid) begin
          consume = 1'b1;
          if (in_last) state_d = ST_HDR;
        end
        default: state_d = ST_INIT;
      endcase
      // Common end-of-packet handling for every word after the header.
      if (body) begin
        words_left_d = words_left_q - 16'd1;
        if (sid_drop) begin
          state_d = in_last ? ST_HDR : ST_DROP;
        end else if (early_last) begin
          cnt_inc[C_SIZE] = 1'b1;
          state_d         = ST_HDR;
        end else if (wl_end) begin
          if (!in_last) cnt_inc[C_SIZE] = 1'b1;
          state_d = in_last ? ST_HDR : ST_DROP;
        end else begin
          state_d = nom_next;
        end
      end
    end
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      state_q      <= ST_INIT;
      words_left_q <= '0;
      {c_q, t_q, tsi_q, tsf_q} <= '0;
      cnt_q        <= '0;
      ch_q         <= '0;
      for (int k = 0; k < N_CH; k++) begin exp_cnt[k] <= 4'hF; last_tsi[k] <= '0; end
      for (int i = 0; i < 7; i++) cnt_r[i] <= '0;
    end else if (soft_rst) begin
      state_q      <= ST_INIT;
      words_left_q <= '0;
      {c_q, t_q, tsi_q, tsf_q} <= '0;
      cnt_q        <= '0;
      ch_q         <= '0;
      for (int k = 0; k < N_CH; k++) begin exp_cnt[k] <= 4'hF; last_tsi[k] <= '0; end
      for (int i = 0; i < 7; i++) cnt_r[i] <= '0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      if (load_hdr) begin
        {c_q, t_q, tsi_q, tsf_q} <= {hdr_c, hdr_t, hdr_tsi_nz, hdr_tsf_nz};
        cnt_q <= in_data[HDR_CNT_HI:HDR_CNT_LO];
      end
      if (ch_load) ch_q <= match_idx;
      if (upd_exp) exp_cnt[match_idx] <= cnt_q;
      if (upd_tsi) last_tsi[ch_q] <= in_data;
      for (int i = 0; i < 7; i++) begin
        if (cnt_inc[i] && cnt_r[i] != '1) cnt_r[i] <= cnt_r[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      m_dest_q  <= '0;
    end else if (soft_rst) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      m_dest_q  <= '0;
    end else if (out_push) begin
      m_valid_q <= 1'b1;
      m_last_q  <= out_last_d;
      m_data_q  <= in_data;
      m_dest_q  <= out_dest_d;
    end else if (m_axis.TREADY) begin
      m_valid_q <= 1'b0;
    end
  end

  assign m_axis.TVALID = m_valid_q;
  assign m_axis.TLAST  = m_last_q;
  assign m_axis.TDATA  = m_data_q;
  assign m_axis.TDEST  = m_dest_q;

  assign pkt_recv      = cnt_r[C_RECV];
  assign pkt_dropped   = cnt_r[C_DROP];
  assign pkt_size_err  = cnt_r[C_SIZE];
  assign pkt_type_err  = cnt_r[C_TYPE];
  assign pkt_order_err = cnt_r[C_ORDER];
  assign ts_order_err  = cnt_r[C_TS];
  assign strm_id_err   = cnt_r[C_SID];

  // Bit 2 summarises dropped packets.
  assign status = {ctrl[0], ctrl[1], ctrl[2], 1'b0, 20'h0,
                   |cnt_r[C_SIZE], |cnt_r[C_TYPE], |cnt_r[C_ORDER], |cnt_r[C_TS],
                   |cnt_r[C_SID], |cnt_r[C_DROP], 2'b00};

endmodule

// File: tb/tb_vita49_unpack_mc.sv
// tb/tb_vita49_unpack_mc.sv - scoreboard testbench for vita49_unpack_mc
module tb_vita49_unpack_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vita49_unpack_mc_if #(.DEST_W(2)) s_if ();
  vita49_unpack_mc_if #(.DEST_W(2)) m_if ();

  logic        trig = 1'b0;
  logic [31:0] ctrl = 32'h0;
  logic [127:0] stream_id = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
  logic [3:0]  ch_en = 4'hF;
  logic [31:0] status;
  logic [7:0]  pkt_recv, pkt_dropped, pkt_size_err, pkt_type_err, pkt_order_err, ts_order_err, strm_id_err;

  vita49_unpack_mc #(.N_CH(4), .CH_W(2), .CNT_W(8)) dut (
    .AXIS_ACLK(clk), .AXIS_ARESET(rst), .s_axis(s_if), .m_axis(m_if),
    .trig(trig), .ctrl(ctrl), .stream_id(stream_id), .ch_en(ch_en), .status(status),
    .pkt_recv(pkt_recv), .pkt_dropped(pkt_dropped), .pkt_size_err(pkt_size_err),
    .pkt_type_err(pkt_type_err), .pkt_order_err(pkt_order_err),
    .ts_order_err(ts_order_err), .strm_id_err(strm_id_err)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [1:0]  dest;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] pkt[$];
  int          checks = 0;
  int          failures = 0;
  int          ready_mode = 0;   // 0 always ready, 1 random 30%, 2 never ready

  assign s_if.TDEST = 2'b00;

  initial begin
    s_if.TDATA = '0; s_if.TVALID = 1'b0; s_if.TLAST = 1'b0; m_if.TREADY = 1'b1;
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_if.TREADY = 1'b1;
      1:       m_if.TREADY = ($urandom_range(0, 99) < 30);
      default: m_if.TREADY = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks hold-while-stalled.
  initial begin : monitor
    beat_t e;
    logic pv, pr, pl;
    logic [31:0] pd;
    logic [1:0] pdst;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pdst = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          checks++;
          if (!(m_if.TVALID && m_if.TDATA == pd && m_if.TLAST == pl && m_if.TDEST == pdst)) begin
            failures++;
            $display("FAIL hold: got v=%0b d=%08h l=%0b dest=%0d expected v=1 d=%08h l=%0b dest=%0d",
                     m_if.TVALID, m_if.TDATA, m_if.TLAST, m_if.TDEST, pd, pl, pdst);
          end
        end
        if (m_if.TVALID && m_if.TREADY) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL beat: got unexpected d=%08h l=%0b dest=%0d expected no beat",
                     m_if.TDATA, m_if.TLAST, m_if.TDEST);
          end else begin
            e = exp_q.pop_front();
            if (m_if.TDATA !== e.d || m_if.TLAST !== e.l || m_if.TDEST !== e.dest) begin
              failures++;
              $display("FAIL beat: got d=%08h l=%0b dest=%0d expected d=%08h l=%0b dest=%0d",
                       m_if.TDATA, m_if.TLAST, m_if.TDEST, e.d, e.l, e.dest);
            end
          end
        end
        pv = m_if.TVALID; pr = m_if.TREADY; pd = m_if.TDATA; pl = m_if.TLAST; pdst = m_if.TDEST;
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic l);
    s_if.TDATA = d; s_if.TLAST = l; s_if.TVALID = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (s_if.TREADY) begin
        @(posedge clk); #1;
        s_if.TVALID = 1'b0;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL send_timeout: got no TREADY in 2000 cycles expected TREADY");
    s_if.TVALID = 1'b0;
  endtask

  task automatic send_pkt();
    for (int i = 0; i < pkt.size(); i++) send_word(pkt[i], i == pkt.size() - 1);
    pkt.delete();
  endtask

  task automatic add_pay(input int n, input logic [1:0] dest, input logic [31:0] base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      pkt.push_back(base + i);
      b.d = base + i; b.l = (i == n - 1); b.dest = dest;
      exp_q.push_back(b);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin @(posedge clk); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d beats outstanding expected 0", exp_q.size());
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    trig = 1'b1; @(posedge clk); #1; trig = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", {31'd0, m_if.TVALID}, 0);
    check("rst_tready", {31'd0, s_if.TREADY}, 1);
    check("rst_recv", pkt_recv, 0);
    check("rst_status", status, 0);
    rst = 1'b0;
    ctrl = 32'h1;
    @(posedge clk); #1;
    start_run();

    // Plain packet on ch2.
    pkt.push_back(32'h1000_0008); pkt.push_back(32'h0000_00A2);
    add_pay(6, 2'd2, 32'h2000_0000);
    send_pkt(); drain();
    check("t1_recv", pkt_recv, 1);

    // C, T, TSI, TSF on ch3: size 12 = 7 header words + 4 payload + trailer.
    pkt.push_back(32'h1C50_000C); pkt.push_back(32'h0000_00A3);
    pkt.push_back(32'h1111_1111); pkt.push_back(32'h2222_2222);
    pkt.push_back(32'd100); pkt.push_back(32'h0); pkt.push_back(32'h5);
    add_pay(4, 2'd3, 32'h3000_0000);
    pkt.push_back(32'hFFFF_0000);
    send_pkt(); drain();
    check("t2_recv", pkt_recv, 2);
    check("t2_size", pkt_size_err, 0);

    // Unknown stream ID, then a good ch3 packet.
    pkt.push_back(32'h1000_0008); pkt.push_back(32'hDEAD_BEEF);
    for (int i = 0; i < 6; i++) pkt.push_back(32'h4000_0000 + i);
    send_pkt();
    pkt.push_back(32'h1001_0008); pkt.push_back(32'h0000_00A3);
    add_pay(6, 2'd3, 32'h5000_0000);
    send_pkt(); drain();
    check("t3_sid", strm_id_err, 1);
    check("t3_drop", pkt_dropped, 1);

    // Ch0 counts 0,1,3 with ch1 count 0 interleaved; then ch3 TSI going backwards.
    pkt.push_back(32'h1000_0004); pkt.push_back(32'h0000_00A0); add_pay(2, 2'd0, 32'h6000_0000); send_pkt();
    pkt.push_back(32'h1000_0004); pkt.push_back(32'h0000_00A1); add_pay(2, 2'd1, 32'h6100_0000); send_pkt();
    pkt.push_back(32'h1001_0004); pkt.push_back(32'h0000_00A0); add_pay(2, 2'd0, 32'h6200_0000); send_pkt();
    pkt.push_back(32'h1003_0004); pkt.push_back(32'h0000_00A0); add_pay(2, 2'd0, 32'h6300_0000); send_pkt();
    pkt.push_back(32'h1042_0005); pkt.push_back(32'h0000_00A3); pkt.push_back(32'd50);
    add_pay(2, 2'd3, 32'h6400_0000); send_pkt();
    drain();
    check("t4_order", pkt_order_err, 1);
    check("t4_ts", ts_order_err, 1);

    // Early TLAST on word 5, then a size-8 packet carrying 10 words.
    pkt.push_back(32'h1001_0008); pkt.push_back(32'h0000_00A2);
    add_pay(3, 2'd2, 32'h7000_0000); send_pkt();
    pkt.push_back(32'h1002_0008); pkt.push_back(32'h0000_00A2);
    add_pay(6, 2'd2, 32'h7100_0000);
    pkt.push_back(32'h7200_0000); pkt.push_back(32'h7200_0001);
    send_pkt(); drain();
    check("t5_size", pkt_size_err, 2);
    check("t5_drop", pkt_dropped, 1);
    check("t5_recv", pkt_recv, 11);
    check("t5_status", status, 32'h8000_00BC);

    // Passthrough: raw words out on TDEST 0, counters frozen.
    ctrl = 32'h5;
    begin
      beat_t b;
      b.d = 32'h1234_5678; b.l = 1'b0; b.dest = 2'd0; exp_q.push_back(b);
      b.d = 32'h9ABC_DEF0; b.l = 1'b1; exp_q.push_back(b);
    end
    send_word(32'h1234_5678, 1'b0); send_word(32'h9ABC_DEF0, 1'b1);
    drain();
    check("pass_recv", pkt_recv, 11);
    ctrl = 32'h1;

    // Random backpressure on ch1.
    ready_mode = 1;
    for (int p = 1; p <= 3; p++) begin
      pkt.push_back(32'h1000_000A | (p << 16)); pkt.push_back(32'h0000_00A1);
      add_pay(8, 2'd1, 32'h8000_0000 + (p << 8));
      send_pkt();
    end
    drain();
    check("t7_recv", pkt_recv, 14);
    check("t7_order", pkt_order_err, 1);

    // Async reset with a beat stalled at the output.
    ready_mode = 2;
    @(posedge clk); #1;
    send_word(32'h1003_0008, 1'b0); send_word(32'h0000_00A2, 1'b0);
    send_word(32'h9000_0000, 1'b0); send_word(32'h9000_0001, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_valid", {31'd0, m_if.TVALID}, 1);
    #2; rst = 1'b1; #1;
    check("arst_tvalid", {31'd0, m_if.TVALID}, 0);
    check("arst_tlast", {31'd0, m_if.TLAST}, 0);
    check("arst_tdest", {30'd0, m_if.TDEST}, 0);
    check("arst_tdata", m_if.TDATA, 0);
    check("arst_recv", pkt_recv, 0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; ready_mode = 0;
    @(posedge clk); #1;
    start_run();

    // Counter saturation on 300 bad-type headers.
    for (int i = 0; i < 300; i++) send_word(32'h0000_0001, 1'b1);
    drain();
    check("sat_type", pkt_type_err, 8'hFF);
    check("sat_recv", pkt_recv, 8'hFF);
    check("sat_status", status, 32'h8000_0044);

    // Soft reset clears the counters.
    ctrl = 32'h3; @(posedge clk); #1; ctrl = 32'h1; @(posedge clk); #1;
    check("srst_type", pkt_type_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
